// File: rtl/mem_stage_ctl_if.sv
// Data-memory req/ack bus between the MEM-stage controller and the data memory.
interface mem_stage_ctl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_stage_ctl.sv
// MEM stage controller: runs the data-memory access for the EX/MEM entry and fills MEM/WB.
// Optional misaligned-access trap is enabled by defining MEM_ALIGN_CHK_EN.
module mem_stage_ctl #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [1:0]             wb_ctlout,
   input  logic                   branch,
   input  logic                   memread,
   input  logic                   memwrite,
   input  logic [31:0]            add_result,
   input  logic                   zero,
   input  logic [31:0]            alu_result,
   input  logic [31:0]            rdata2out,
   input  logic [4:0]             five_bit_muxout,
   output logic                   stall,
   output logic                   pcsrc,
   output logic [31:0]            branch_target,
   mem_stage_ctl_if.master        mem,
   output logic                   wb_valid,
   output logic [1:0]             wb_ctl,
   output logic [31:0]            read_data,
   output logic [31:0]            mem_alu_result,
   output logic [4:0]             wb_reg,
   output logic                   bus_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             acc;
   logic             misalign;
   logic [1:0]       lat_ctl;
   logic [31:0]      lat_alu;
   logic [4:0]       lat_reg;
   logic             lat_rd;

   assign acc           = in_valid & (memread | memwrite);
   assign pcsrc         = in_valid & branch & zero;
   assign branch_target = add_result;

`ifdef MEM_ALIGN_CHK_EN
   assign misalign = (alu_result[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      stall = 1'b0;
      if (state == S_IDLE) stall = acc & ~misalign;
      else                 stall = ~mem.mem_ack;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         mem.mem_req    <= 1'b0;
         mem.mem_we     <= 1'b0;
         mem.mem_addr   <= '0;
         mem.mem_wdata  <= '0;
         wb_valid       <= 1'b0;
         wb_ctl         <= '0;
         read_data      <= '0;
         mem_alu_result <= '0;
         wb_reg         <= '0;
         bus_err        <= 1'b0;
         lat_ctl        <= '0;
         lat_alu        <= '0;
         lat_reg        <= '0;
         lat_rd         <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         bus_err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (in_valid && !acc) begin
                  wb_valid       <= 1'b1;
                  wb_ctl         <= wb_ctlout;
                  mem_alu_result <= alu_result;
                  wb_reg         <= five_bit_muxout;
                  read_data      <= '0;
               end else if (acc && misalign) begin
                  // trapped access: retire immediately with writeback suppressed
                  wb_valid       <= 1'b1;
                  bus_err        <= 1'b1;
                  wb_ctl         <= '0;
                  read_data      <= '0;
                  mem_alu_result <= alu_result;
                  wb_reg         <= five_bit_muxout;
               end else if (acc) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= memwrite;
                  mem.mem_addr  <= alu_result;
                  mem.mem_wdata <= rdata2out;
                  lat_ctl       <= wb_ctlout;
                  lat_alu       <= alu_result;
                  lat_reg       <= five_bit_muxout;
                  lat_rd        <= memread & ~memwrite;
                  cnt           <= '0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem.mem_ack) begin
                  mem.mem_req    <= 1'b0;
                  read_data      <= lat_rd ? mem.mem_rdata : '0;
                  wb_valid       <= 1'b1;
                  wb_ctl         <= lat_ctl;
                  mem_alu_result <= lat_alu;
                  wb_reg         <= lat_reg;
                  state          <= S_IDLE;
               end else if (cnt == TMO_LAST) begin
                  mem.mem_req    <= 1'b0;
                  bus_err        <= 1'b1;
                  wb_valid       <= 1'b1;
                  wb_ctl         <= '0;
                  read_data      <= '0;
                  mem_alu_result <= lat_alu;
                  wb_reg         <= lat_reg;
                  state          <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctl.sv
// Scoreboard bench for mem_stage_ctl (built with TIMEOUT_CYCLES=4); checks outputs at negedge.
module tb_mem_stage_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  wb_ctlout;
   logic        branch, memread, memwrite, zero;
   logic [31:0] add_result, alu_result, rdata2out;
   logic [4:0]  five_bit_muxout;
   logic        stall, pcsrc;
   logic [31:0] branch_target;
   logic        wb_valid, bus_err;
   logic [1:0]  wb_ctl;
   logic [31:0] read_data, mem_alu_result;
   logic [4:0]  wb_reg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  ctl;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rg;
      logic        err;
   } exp_t;

   exp_t sb[$];

   mem_stage_ctl_if bus();

   mem_stage_ctl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wb_ctlout(wb_ctlout),
      .branch(branch), .memread(memread), .memwrite(memwrite),
      .add_result(add_result), .zero(zero), .alu_result(alu_result),
      .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
      .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
      .mem(bus),
      .wb_valid(wb_valid), .wb_ctl(wb_ctl), .read_data(read_data),
      .mem_alu_result(mem_alu_result), .wb_reg(wb_reg), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      in_valid = 0; wb_ctlout = 0; branch = 0; memread = 0; memwrite = 0;
      add_result = 0; zero = 0; alu_result = 0; rdata2out = 0; five_bit_muxout = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;
   endtask

   task automatic drive_op(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rg, input logic [1:0] ctl);
      in_valid = 1; memread = rd; memwrite = wr; alu_result = addr;
      rdata2out = wd; five_bit_muxout = rg; wb_ctlout = ctl;
   endtask

   // Waits (bounded) for the wb_valid pulse, pops the expected entry and compares it.
   task automatic wait_wb(input string name, output int lat);
      exp_t e;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         if (wb_valid === 1'b1) begin lat = c; break; end
         @(negedge clk);
      end
      checks++;
      if (lat < 0) begin
         errors++;
         $display("FAIL %s: wb_valid never asserted (timeout), required 1", name);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      checks++;
      if (wb_ctl !== e.ctl) begin
         errors++; $display("FAIL %s wb_ctl: got %0h required %0h", name, wb_ctl, e.ctl);
      end
      checks++;
      if (bus_err !== e.err) begin
         errors++; $display("FAIL %s bus_err: got %0b required %0b", name, bus_err, e.err);
      end
      if (!e.err) begin
         checks++;
         if (read_data !== e.rdata) begin
            errors++; $display("FAIL %s read_data: got %08h required %08h", name, read_data, e.rdata);
         end
         checks++;
         if (mem_alu_result !== e.alu) begin
            errors++; $display("FAIL %s mem_alu_result: got %08h required %08h", name, mem_alu_result, e.alu);
         end
         checks++;
         if (wb_reg !== e.rg) begin
            errors++; $display("FAIL %s wb_reg: got %0d required %0d", name, wb_reg, e.rg);
         end
      end
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || bus_err !== 1'b0) begin
         errors++; $display("FAIL %s pulse_width: wb_valid=%0b bus_err=%0b required 0/0", name, wb_valid, bus_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, wb_valid, bus_err, stall} !== 5'b0 ||
          bus.mem_addr !== 0 || bus.mem_wdata !== 0 || wb_ctl !== 0 ||
          read_data !== 0 || mem_alu_result !== 0 || wb_reg !== 0) begin
         errors++;
         $display("FAIL reset_state: req=%0b we=%0b wbv=%0b err=%0b stall=%0b addr=%08h rd=%08h alu=%08h required all 0",
                  bus.mem_req, bus.mem_we, wb_valid, bus_err, stall, bus.mem_addr, read_data, mem_alu_result);
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_nonmem();
      int lat;
      drive_op(0, 0, 32'h1234, 0, 5'd5, 2'b10);
      sb.push_back('{ctl: 2'b10, rdata: 0, alu: 32'h1234, rg: 5'd5, err: 0});
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %0b required 0", stall); end
      @(negedge clk);
      idle_inputs();
      wait_wb("nonmem", lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL nonmem_latency: got %0d extra cycles required 0", lat); end
      // outputs hold while idle, stray ack ignored
      bus.mem_ack = 1;
      repeat (2) @(negedge clk);
      bus.mem_ack = 0;
      checks++;
      if (wb_valid !== 0 || bus.mem_req !== 0 || mem_alu_result !== 32'h1234 || wb_reg !== 5'd5) begin
         errors++;
         $display("FAIL idle_hold: wbv=%0b req=%0b alu=%08h reg=%0d required 0/0/00001234/5",
                  wb_valid, bus.mem_req, mem_alu_result, wb_reg);
      end
   endtask

   task automatic test_load();
      int lat;
      drive_op(1, 0, 32'h100, 32'h5555, 5'd7, 2'b11);
      sb.push_back('{ctl: 2'b11, rdata: 32'hDEADBEEF, alu: 32'h100, rg: 5'd7, err: 0});
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_idle: got %0b required 1", stall); end
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.mem_req !== 1 || bus.mem_we !== 0 || bus.mem_addr !== 32'h100 || stall !== 1 || wb_valid !== 0) begin
            errors++;
            $display("FAIL load_wait%0d: req=%0b we=%0b addr=%08h stall=%0b wbv=%0b required 1/0/00000100/1/0",
                     i, bus.mem_req, bus.mem_we, bus.mem_addr, stall, wb_valid);
         end
         @(negedge clk);
      end
      bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL load_stall_ack: got %0b required 0", stall); end
      @(negedge clk);
      bus.mem_ack = 0; bus.mem_rdata = 0;
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %0b required 0", bus.mem_req); end
      wait_wb("load", lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL load_latency: got %0d extra cycles required 0", lat); end
   endtask

   task automatic test_store();
      int lat;
      // second pass sets memread too: write must win and read_data stays 0
      for (int p = 0; p < 2; p++) begin
         drive_op(p[0], 1, 32'h200, 32'hCAFEF00D, 5'd9, 2'b01);
         sb.push_back('{ctl: 2'b01, rdata: 0, alu: 32'h200, rg: 5'd9, err: 0});
         @(negedge clk);
         idle_inputs();
         bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD0BAD;
         #1;
         checks++;
         if (bus.mem_req !== 1 || bus.mem_we !== 1 || bus.mem_wdata !== 32'hCAFEF00D ||
             bus.mem_addr !== 32'h200 || stall !== 0) begin
            errors++;
            $display("FAIL store%0d_bus: req=%0b we=%0b wdata=%08h addr=%08h stall=%0b required 1/1/cafef00d/00000200/0",
                     p, bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_addr, stall);
         end
         @(negedge clk);
         bus.mem_ack = 0; bus.mem_rdata = 0;
         wait_wb(p ? "store_rw" : "store", lat);
         checks++;
         if (lat != 0) begin errors++; $display("FAIL store%0d_latency: got %0d required 0", p, lat); end
      end
   endtask

   task automatic test_timeout();
      int lat;
      drive_op(1, 0, 32'h300, 0, 5'd3, 2'b11);
      sb.push_back('{ctl: 2'b00, rdata: 0, alu: 32'h300, rg: 5'd3, err: 1});
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.mem_req !== 1 || bus_err !== 0 || wb_valid !== 0) begin
            errors++;
            $display("FAIL timeout_wait%0d: req=%0b err=%0b wbv=%0b required 1/0/0", i, bus.mem_req, bus_err, wb_valid);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req: got %0b required 0", bus.mem_req); end
      wait_wb("timeout", lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL timeout_latency: got %0d required 0", lat); end
      // ack on the last permitted cycle beats the timeout
      drive_op(1, 0, 32'h304, 0, 5'd4, 2'b10);
      sb.push_back('{ctl: 2'b10, rdata: 32'h600DF00D, alu: 32'h304, rg: 5'd4, err: 0});
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      bus.mem_ack = 1; bus.mem_rdata = 32'h600DF00D;
      @(negedge clk);
      bus.mem_ack = 0; bus.mem_rdata = 0;
      wait_wb("ack_at_timeout", lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL ack_at_timeout_latency: got %0d required 0", lat); end
   endtask

   task automatic test_reset_mid_wait();
      int lat;
      drive_op(1, 0, 32'h400, 0, 5'd1, 2'b11);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstwait_req_before: got %0b required 1", bus.mem_req); end
      rst_n = 0;
      #1;
      checks++;
      if (bus.mem_req !== 0 || wb_valid !== 0 || bus_err !== 0) begin
         errors++;
         $display("FAIL rstwait_async: req=%0b wbv=%0b err=%0b required 0/0/0", bus.mem_req, wb_valid, bus_err);
      end
      @(negedge clk);
      rst_n = 1;
      bus.mem_ack = 1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (wb_valid !== 0 || bus.mem_req !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL rstwait_after: wbv=%0b req=%0b stall=%0b required 0/0/0", wb_valid, bus.mem_req, stall);
         end
      end
      bus.mem_ack = 0;
      drive_op(0, 0, 32'h55, 0, 5'd2, 2'b01);
      sb.push_back('{ctl: 2'b01, rdata: 0, alu: 32'h55, rg: 5'd2, err: 0});
      @(negedge clk);
      idle_inputs();
      wait_wb("post_reset_op", lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL post_reset_latency: got %0d required 0", lat); end
   endtask

   task automatic test_branch();
      in_valid = 1; branch = 1; zero = 1; add_result = 32'h40;
      #1;
      checks++;
      if (pcsrc !== 1 || branch_target !== 32'h40) begin
         errors++; $display("FAIL branch_taken: pcsrc=%0b target=%08h required 1/00000040", pcsrc, branch_target);
      end
      zero = 0;
      #1;
      checks++;
      if (pcsrc !== 0) begin errors++; $display("FAIL branch_nottaken: pcsrc=%0b required 0", pcsrc); end
      zero = 1; in_valid = 0;
      #1;
      checks++;
      if (pcsrc !== 0) begin errors++; $display("FAIL branch_invalid: pcsrc=%0b required 0", pcsrc); end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_align();
      int lat;
      drive_op(1, 0, 32'h102, 0, 5'd6, 2'b11);
`ifdef MEM_ALIGN_CHK_EN
      sb.push_back('{ctl: 2'b00, rdata: 0, alu: 32'h102, rg: 5'd6, err: 1});
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL align_stall: got %0b required 0", stall); end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL align_req: got %0b required 0", bus.mem_req); end
      wait_wb("align_trap", lat);
`else
      sb.push_back('{ctl: 2'b11, rdata: 32'h12345678, alu: 32'h102, rg: 5'd6, err: 0});
      @(negedge clk);
      idle_inputs();
      checks++;
      if (bus.mem_req !== 1 || bus.mem_addr !== 32'h102) begin
         errors++; $display("FAIL misaligned_pass: req=%0b addr=%08h required 1/00000102", bus.mem_req, bus.mem_addr);
      end
      bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
      @(negedge clk);
      bus.mem_ack = 0; bus.mem_rdata = 0;
      wait_wb("misaligned_load", lat);
`endif
      checks++;
      if (lat != 0) begin errors++; $display("FAIL align_latency: got %0d required 0", lat); end
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_load();
      test_store();
      test_timeout();
      test_reset_mid_wait();
      test_branch();
      test_align();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctl.md
Name: mem_stage_ctl

Overview:
- Consumer side of the EX/MEM pipeline register: takes the EX/MEM outputs, executes the data-memory access over a req/ack bus, and produces MEM/WB register outputs.
- Sits between the EX/MEM register and the MEM/WB register.
- Resolves the branch decision for the fetch stage.
- Holds the upstream pipeline with a stall signal while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in WAIT without mem_ack before the access is abandoned. Legal range 2..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  EX/MEM entry holds a valid instruction.
- wb_ctlout  input  2  writeback control from EX/MEM.
- branch  input  1  branch instruction flag.
- memread  input  1  load flag.
- memwrite  input  1  store flag.
- add_result  input  32  branch target.
- zero  input  1  ALU zero flag.
- alu_result  input  32  ALU result / memory address.
- rdata2out  input  32  store data.
- five_bit_muxout  input  5  destination register.
- stall  output  1  combinational; hold EX/MEM and earlier stages.
- pcsrc  output  1  combinational, in_valid & branch & zero.
- branch_target  output  32  combinational copy of add_result.
- mem_req  output  1  registered memory request.
- mem_we  output  1  registered; 1 = write.
- mem_addr  output  32  registered.
- mem_wdata  output  32  registered.
- mem_ack  input  1  memory completion, sampled only in WAIT.
- mem_rdata  input  32  read data, valid with mem_ack.
- wb_valid  output  1  registered one-cycle pulse; MEM/WB entry valid.
- wb_ctl  output  2  registered writeback control.
- read_data  output  32  registered load data.
- mem_alu_result  output  32  registered ALU result.
- wb_reg  output  5  registered destination register.
- bus_err  output  1  registered one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; counter 0; every registered output 0. stall, pcsrc and branch_target follow their equations.
- Access request: acc = in_valid & (memread | memwrite).
- FSM states: IDLE, WAIT.
- IDLE, in_valid & !acc:
  - Next edge: wb_valid=1, wb_ctl=wb_ctlout, mem_alu_result=alu_result, wb_reg=five_bit_muxout, read_data=0. Latency 1 cycle.
  - stall=0.
- IDLE, acc:
  - stall=1.
  - Next edge: mem_req=1, mem_we=memwrite, mem_addr=alu_result, mem_wdata=rdata2out. Latch wb_ctlout, alu_result, five_bit_muxout and memread internally. Counter cleared. Go to WAIT.
  - memread & memwrite both set: memwrite wins; read_data is written 0.
- WAIT:
  - stall = !mem_ack.
  - mem_req, mem_we, mem_addr and mem_wdata held stable.
  - Counter increments every cycle without mem_ack.
- WAIT, mem_ack=1:
  - Next edge: mem_req=0; read_data = latched memread ? mem_rdata : 0; wb_valid=1; wb fields from the latched copies; go to IDLE.
  - Total latency = 2 + k cycles, where k is the number of cycles before ack.
- WAIT, counter reaches TIMEOUT_CYCLES-1 with no ack:
  - Next edge: mem_req=0, bus_err=1, wb_valid=1 with wb_ctl=0 (writeback suppressed); go to IDLE.
  - mem_ack on the same cycle as the timeout: ack wins, no bus_err.
- IDLE, in_valid=0: wb_valid=0; all other registered outputs hold their values.
- wb_valid and bus_err are high for exactly one cycle per event.
- mem_ack while in IDLE is ignored.
- EX/MEM inputs are don't-care in WAIT; upstream holds them because stall=1.
- Reset asserted mid-WAIT: immediate return to IDLE, mem_req=0, no wb_valid pulse after reset releases.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - In IDLE, acc with alu_result[1:0] != 0: no memory request is issued.
  - Next edge: bus_err=1, wb_valid=1, wb_ctl=0; stay in IDLE.
  - stall=0 in that cycle.
- Undefined: no alignment check; misaligned addresses are passed to the bus unchanged.

Test Plan:
- rst_n=0 mid-WAIT with mem_req=1 -> mem_req, wb_valid, bus_err go 0 immediately; state IDLE after release.
- Non-memory op: in_valid=1, alu_result=0x1234, five_bit_muxout=5, wb_ctlout=2'b10 -> next cycle wb_valid=1, mem_alu_result=0x1234, wb_reg=5, wb_ctl=2'b10, stall=0 throughout.
- Load: memread=1, alu_result=0x100; ack after 3 WAIT cycles with mem_rdata=0xDEADBEEF:
  - mem_addr=0x100, mem_we=0 held while waiting; stall=1 until the ack cycle.
  - read_data=0xDEADBEEF, wb_valid pulse once.
- Store: memwrite=1, rdata2out=0xCAFEF00D, alu_result=0x200, ack in first WAIT cycle -> mem_we=1, mem_wdata=0xCAFEF00D, read_data=0, wb_valid one cycle.
- Timeout, TIMEOUT_CYCLES=4, no ack -> after 4 WAIT cycles: bus_err=1, wb_valid=1, wb_ctl=0, mem_req=0. Repeat with ack on the 4th cycle -> normal completion, bus_err=0.
- Branch and alignment:
  - branch=1, zero=1, add_result=0x40 -> pcsrc=1, branch_target=0x40 same cycle.
  - zero=0 -> pcsrc=0.
  - With MEM_ALIGN_CHK_EN, load at 0x102 -> no mem_req; bus_err and wb_valid pulse, wb_ctl=0.
